// File: rtl/handshake_fifo_responder.sv
// handshake_fifo_responder: FIFO-buffered word source for the req/ack pull protocol
module handshake_fifo_responder #(
  parameter int data_width = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  output logic                  overflow,
  output logic [depth_log2:0]   level,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count
);
  localparam int depth = 2 ** depth_log2;
  logic [data_width-1:0] mem [depth];
  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic push, serve;
  assign full  = level == (depth_log2+1)'(depth);
  assign push  = wr_en & ~full;
  assign serve = req & ~ack & (level != '0);
  // storage needs no reset; contents are only read once level says they are valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and the registered handshake response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      ack      <= 1'b0;
      dout     <= '0;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + depth_log2'(push);
      rd_ptr   <= rd_ptr + depth_log2'(serve);
      level    <= level + (depth_log2+1)'(push) - (depth_log2+1)'(serve);
      overflow <= overflow | (wr_en & full);
      ack      <= serve;
      dout     <= serve ? mem[rd_ptr] : dout;
      count    <= count + 32'(serve);
    end
endmodule

// File: tb/tb_handshake_fifo_responder.sv
// tb_handshake_fifo_responder: scoreboard bench for the buffered req/ack responder
module tb_handshake_fifo_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full, overflow, req = 1'b0, ack;
  logic [2:0]  level;
  logic [31:0] dout, count;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  logic        prev_ack = 1'b0;

  handshake_fifo_responder #(.data_width(32), .depth_log2(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .level(level), .req(req), .ack(ack), .dout(dout), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] d, input bit accepted);
    wr_en = 1'b1;
    wr_data = d;
    if (accepted) sb.push_back(d);
  endtask

  // monitor: every ack must deliver the oldest outstanding word and never repeat on the next cycle
  always @(negedge clk)
    if (!rst) begin
      if (ack) begin
        check("ack_gap", 64'(prev_ack), 64'd0);
        if (sb.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
        else check("dout", 64'(dout), 64'(sb.pop_front()));
      end
      prev_ack = ack;
    end else prev_ack = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks;
    tick;
    tick;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick;
    // reset landing on the ack cycle
    set_push(32'h33, 1'b1);
    req = 1'b1;
    tick;
    wr_en = 1'b0;
    tick;
    check("t1_ack_before_rst", 64'(ack), 64'd1);
    rst = 1'b1;
    #1;
    check("t1_ack", 64'(ack), 64'd0);
    check("t1_count", 64'(count), 64'd0);
    check("t1_level", 64'(level), 64'd0);
    check("t1_dout", 64'(dout), 64'd0);
    sb.delete();
    req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    // order and latency with req held high
    req = 1'b1;
    set_push(32'd5, 1'b1);
    tick;
    check("t2_no_bypass", 64'(ack), 64'd0);
    set_push(32'd6, 1'b1);
    tick;
    check("t2_first_ack", 64'(ack), 64'd1);
    check("t2_first_dout", 64'(dout), 64'd5);
    set_push(32'd7, 1'b1);
    tick;
    check("t2_ack_low", 64'(ack), 64'd0);
    wr_en = 1'b0;
    repeat (3) tick;
    req = 1'b0;
    tick;
    check("t2_count", 64'(count), 64'd3);
    check("t2_level", 64'(level), 64'd0);
    // request against an empty FIFO
    req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t3_stall", 64'(ack), 64'd0);
    end
    set_push(32'hA5, 1'b1);
    tick;
    check("t3_push_edge", 64'(ack), 64'd0);
    wr_en = 1'b0;
    tick;
    check("t3_ack", 64'(ack), 64'd1);
    check("t3_dout", 64'(dout), 64'hA5);
    req = 1'b0;
    tick;
    check("t3_count", 64'(count), 64'd4);
    // fill past capacity without pulling
    for (int i = 1; i <= 6; i++) begin
      set_push(32'(i), i <= 4);
      tick;
      if (i == 4) begin
        check("t4_full", 64'(full), 64'd1);
        check("t4_level4", 64'(level), 64'd4);
        check("t4_no_ovf_yet", 64'(overflow), 64'd0);
      end
    end
    wr_en = 1'b0;
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_level", 64'(level), 64'd4);
    req = 1'b1;
    repeat (8) tick;
    req = 1'b0;
    tick;
    check("t4_count", 64'(count), 64'd8);
    check("t4_drained", 64'(level), 64'd0);
    check("t4_not_full", 64'(full), 64'd0);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);
    // push and serve on the same edge at level 2, across several pointer wraps
    set_push(32'd100, 1'b1);
    tick;
    set_push(32'd101, 1'b1);
    tick;
    wr_en = 1'b0;
    check("t5_level_start", 64'(level), 64'd2);
    for (int k = 0; k < 12; k++) begin
      set_push(32'(102 + k), 1'b1);
      req = 1'b1;
      tick;
      check("t5_ack", 64'(ack), 64'd1);
      check("t5_level_a", 64'(level), 64'd2);
      wr_en = 1'b0;
      req = 1'b0;
      tick;
      check("t5_level_b", 64'(level), 64'd2);
    end
    req = 1'b1;
    repeat (4) tick;
    req = 1'b0;
    tick;
    check("t5_count", 64'(count), 64'd22);
    check("t5_level_end", 64'(level), 64'd0);
    // streaming: independent producer and a well-behaved initiator
    acks = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          for (int b = 0; b < 4000 && sb.size() >= 3; b++) tick;
          set_push(32'(1000 + i), 1'b1);
          tick;
          wr_en = 1'b0;
          if ($urandom_range(0, 1) != 0) tick;
        end
      end
      begin
        for (int c = 0; c < 8000 && acks < 200; c++) begin
          tick;
          if (ack) begin
            acks++;
            req = 1'b0;
          end else if (!req) req = $urandom_range(0, 2) != 0;
        end
        req = 1'b0;
      end
    join
    tick;
    tick;
    check("t6_acks", 64'(acks), 64'd200);
    check("t6_count", 64'(count), 64'd222);
    check("t6_level", 64'(level), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    check("t6_no_overflow_growth", 64'(overflow), 64'd1);
    rst = 1'b1;
    #1;
    check("end_rst_overflow", 64'(overflow), 64'd0);
    check("end_rst_count", 64'(count), 64'd0);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
